// File: rtl/count_pkg.sv
// count_pkg: shared constants and helpers for the count_param counter family.
//   cnt_dir_e    : step direction encoding (CNT_DOWN=0, CNT_UP=1)
//   cnt_mode_e   : boundary behaviour encoding (CNT_WRAP=0, CNT_SAT=1)
//   params_legal : elaboration-time legality check for counter parameters
package count_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  // Returns 1 when WIDTH is 2..32, 1 <= MAX_VAL <= 2^WIDTH-1 and
  // RESET_VAL <= MAX_VAL.
  function automatic bit params_legal(input int unsigned     width,
                                      input longint unsigned max_val,
                                      input longint unsigned reset_val);
    if (width < 2 || width > 32) return 1'b0;
    if (max_val < 64'd1 || max_val > ((64'd1 << width) - 64'd1)) return 1'b0;
    if (reset_val > max_val) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/count_param.sv
// count_param: parametrised synchronous up/down counter with modulus,
// parallel load, wrap or saturate at the boundaries, a registered
// terminal-count pulse and a sticky overflow flag.
// Ports:
//   clk      in  1      rising-edge clock
//   reset    in  1      synchronous active-low reset
//   en       in  1      count enable (one step per cycle)
//   up       in  1      direction, 1 = increment, 0 = decrement
//   load     in  1      parallel load strobe (beats en)
//   load_val in  WIDTH  value to load, clamped to MAX_VAL
//   clr_ovf  in  1      clears ovf (a same-cycle boundary event wins)
//   out      out WIDTH  current count
//   check    out 1      one-cycle pulse after each boundary event
//   ovf      out 1      sticky boundary-event flag
module count_param
  import count_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE  = 1'b0,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             check,
  output logic             ovf
);

  generate
    if (!params_legal(WIDTH, MAX_VAL, RESET_VAL)) begin : g_bad_params
      $error("count_param: illegal WIDTH/MAX_VAL/RESET_VAL combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Returns {boundary, next}. The boundary comes from comparing against
  // MAXV or zero rather than from a carry, so any modulus behaves the same.
  function automatic logic [WIDTH:0] next_count(input logic [WIDTH-1:0] cur,
                                                input logic             dir);
    logic             bnd;
    logic [WIDTH-1:0] nxt;
    if (dir == CNT_UP) begin
      bnd = (cur == MAXV);
      if (!bnd)                      nxt = cur + ONE;
      else if (SATURATE == CNT_SAT)  nxt = MAXV;
      else                           nxt = '0;
    end else begin
      bnd = (cur == '0);
      if (!bnd)                      nxt = cur - ONE;
      else if (SATURATE == CNT_SAT)  nxt = '0;
      else                           nxt = MAXV;
    end
    return {bnd, nxt};
  endfunction

  logic [WIDTH:0]   stepped;
  logic [WIDTH-1:0] clamped;
  logic             bnd_event;

  always_comb begin
    stepped   = next_count(out, up);
    clamped   = (load_val > MAXV) ? MAXV : load_val;
    // A load takes the cycle, so it can never produce a boundary event.
    bnd_event = en & ~load & stepped[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out   <= RSTV;
      check <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      check <= bnd_event;
      if (load)    out <= clamped;
      else if (en) out <= stepped[WIDTH-1:0];
      if (bnd_event)    ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule
